// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO next-state (fifo_ns) and datapath (fifo_dp) stages.
// State codes are plain 3-bit constants so both stages agree on the wire encoding.
package fifo_pkg;
    typedef logic [2:0] state_t;

    localparam state_t INIT     = 3'b000;
    localparam state_t WRITE    = 3'b001;
    localparam state_t WR_ERROR = 3'b010;
    localparam state_t READ     = 3'b011;
    localparam state_t RD_ERROR = 3'b100;
    localparam state_t NO_OP    = 3'b101;

    localparam int ADDR_WIDTH_DFLT = 3;
    localparam int DEPTH           = 2 ** ADDR_WIDTH_DFLT;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/fifo_dp_if.sv
// Control/data bundle between fifo_ns (master) and fifo_dp (slave).
// Everything fifo_dp drives is registered or decoded from registers only.
interface fifo_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic [2:0]            next_state;
    logic [DATA_WIDTH-1:0] din;
    logic [2:0]            state;
    logic [ADDR_WIDTH:0]   data_count;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;

    modport master (
        output next_state, din,
        input  state, data_count, dout, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  next_state, din,
        output state, data_count, dout, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, combinational read; latency 0 on read, 1 edge on write.
// No backpressure; contents are not reset and are meaningful only between head and tail.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH_L = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_L];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_dp.sv
// FIFO state register and datapath: applies next_state each edge, results visible one cycle later.
// No backpressure of its own; WRITE when full / READ when empty degrade to the matching error state.
module fifo_dp
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic     clk,
    input  logic     reset_n,
    fifo_dp_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] head_q, head_d;
    logic [ADDR_WIDTH-1:0] tail_q, tail_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (tail_q),
        .wdata (bus.din),
        .raddr (head_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = bus.next_state;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        mem_we  = 1'b0;
        case (bus.next_state)
            INIT: begin
                head_d = '0;
                tail_d = '0;
                cnt_d  = '0;
            end
            WRITE: begin
                // Guard against an upstream decision that would overrun storage.
                if (cnt_q == FULL_CNT) begin
                    state_d = WR_ERROR;
                end else begin
                    mem_we = 1'b1;
                    tail_d = tail_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d = RD_ERROR;
                end else begin
                    dout_d = mem_rdata;
                    head_d = head_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end
            end
            WR_ERROR, RD_ERROR, NO_OP: begin
            end
            default: state_d = NO_OP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.data_count = cnt_q;
    assign bus.dout       = dout_q;
    assign bus.full       = (cnt_q == FULL_CNT);
    assign bus.empty      = (cnt_q == '0);
    assign bus.wr_ack     = (state_q == WRITE);
    assign bus.wr_err     = (state_q == WR_ERROR);
    assign bus.rd_ack     = (state_q == READ);
    assign bus.rd_err     = (state_q == RD_ERROR);
endmodule

// File: tb/tb_fifo_dp.sv
// Bench for fifo_dp: queue-based reference model compared every negedge, plus literal spot checks.
module tb_fifo_dp;
    import fifo_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    bit   run;

    fifo_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

    fifo_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the FIFO as a queue of words plus the last committed state and read word.
    logic [31:0] m_q [$];
    logic [31:0] m_dout;
    logic [2:0]  m_state;

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_state = INIT;
    endtask

    task automatic model_update(input logic [2:0] ns, input logic [31:0] d);
        case (ns)
            3'd0: begin m_q.delete(); m_state = INIT; end
            3'd1: begin
                if (m_q.size() == 8) m_state = WR_ERROR;
                else begin m_q.push_back(d); m_state = WRITE; end
            end
            3'd3: begin
                if (m_q.size() == 0) m_state = RD_ERROR;
                else begin m_dout = m_q.pop_front(); m_state = READ; end
            end
            3'd2, 3'd4, 3'd5: m_state = ns;
            default: m_state = NO_OP;
        endcase
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("m.state",  64'(bus.state),      64'(m_state));
            chk("m.count",  64'(bus.data_count), 64'(m_q.size()));
            chk("m.dout",   64'(bus.dout),       64'(m_dout));
            chk("m.full",   64'(bus.full),       64'(m_q.size() == 8));
            chk("m.empty",  64'(bus.empty),      64'(m_q.size() == 0));
            chk("m.wr_ack", 64'(bus.wr_ack),     64'(m_state == WRITE));
            chk("m.wr_err", 64'(bus.wr_err),     64'(m_state == WR_ERROR));
            chk("m.rd_ack", 64'(bus.rd_ack),     64'(m_state == READ));
            chk("m.rd_err", 64'(bus.rd_err),     64'(m_state == RD_ERROR));
        end
    end

    task automatic step(input logic [2:0] ns, input logic [31:0] d);
        bus.next_state = ns;
        bus.din        = d;
        @(posedge clk);
        model_update(ns, d);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] hold_dout;
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.next_state = NO_OP;
        bus.din        = '0;
        model_reset();
        #1;
        chk("rst.state", 64'(bus.state), 64'h0);
        chk("rst.empty", 64'(bus.empty), 64'h1);
        chk("rst.dout",  64'(bus.dout),  64'h0);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Mid-stream asynchronous reset
        step(WRITE, 32'h1);
        step(WRITE, 32'h2);
        step(WRITE, 32'h3);
        step(READ, 32'h0);
        chk("pre_rst.dout", 64'(bus.dout), 64'h1);
        bus.next_state = NO_OP;
        @(posedge clk);
        model_update(NO_OP, 32'h0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst.state", 64'(bus.state),      64'h0);
        chk("arst.count", 64'(bus.data_count), 64'h0);
        chk("arst.empty", 64'(bus.empty),      64'h1);
        chk("arst.dout",  64'(bus.dout),       64'h0);
        chk("arst.flags", 64'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err, bus.full}), 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, then overrun
        for (int i = 1; i <= 8; i++) begin
            step(WRITE, 32'(i * 32'h11));
            chk("fill.count",  64'(bus.data_count), 64'(i));
            chk("fill.wr_ack", 64'(bus.wr_ack),     64'h1);
        end
        chk("fill.full",  64'(bus.full),  64'h1);
        chk("fill.empty", 64'(bus.empty), 64'h0);
        step(WRITE, 32'hDEAD);
        chk("ovr.state", 64'(bus.state),      64'(WR_ERROR));
        chk("ovr.count", 64'(bus.data_count), 64'h8);

        // Drain in order, then underrun
        for (int i = 1; i <= 8; i++) begin
            step(READ, 32'h0);
            chk("drain.dout",   64'(bus.dout),   64'(i * 32'h11));
            chk("drain.rd_ack", 64'(bus.rd_ack), 64'h1);
        end
        chk("drain.empty", 64'(bus.empty), 64'h1);
        step(READ, 32'h0);
        chk("udr.rd_err", 64'(bus.rd_err), 64'h1);
        chk("udr.dout",   64'(bus.dout),   64'h88);

        // Wrap-around past entry 7
        for (int i = 1; i <= 5; i++) step(WRITE, 32'(i));
        for (int i = 1; i <= 5; i++) begin
            step(READ, 32'h0);
            chk("wrap5.dout", 64'(bus.dout), 64'(i));
        end
        for (int i = 0; i < 6; i++) step(WRITE, 32'(32'hAA + i * 32'h11));
        for (int i = 0; i < 6; i++) begin
            step(READ, 32'h0);
            chk("wrap6.dout", 64'(bus.dout), 64'(32'hAA + i * 32'h11));
        end
        chk("wrap.count", 64'(bus.data_count), 64'h0);

        // Hold states and illegal code with three entries resident
        for (int i = 0; i < 4; i++) step(WRITE, 32'(32'hC0 + i));
        step(READ, 32'h0);
        hold_dout = bus.dout;
        chk("hold.pre_dout", 64'(hold_dout), 64'hC0);
        step(NO_OP, 32'hBAD);
        step(WR_ERROR, 32'hBAD);
        step(RD_ERROR, 32'hBAD);
        step(3'b111, 32'hBAD);
        chk("hold.state", 64'(bus.state),      64'(NO_OP));
        chk("hold.count", 64'(bus.data_count), 64'h3);
        chk("hold.dout",  64'(bus.dout),       64'(hold_dout));
        step(3'b110, 32'hBAD);
        chk("ill6.state", 64'(bus.state), 64'(NO_OP));
        for (int i = 1; i <= 3; i++) begin
            step(READ, 32'h0);
            chk("hold.read", 64'(bus.dout), 64'(32'hC0 + i));
        end

        // INIT flush
        for (int i = 0; i < 4; i++) step(WRITE, 32'(32'h70 + i));
        chk("flush.pre", 64'(bus.data_count), 64'h4);
        step(INIT, 32'h0);
        chk("flush.count", 64'(bus.data_count), 64'h0);
        chk("flush.empty", 64'(bus.empty),      64'h1);
        step(WRITE, 32'h5A);
        step(READ, 32'h0);
        chk("flush.read", 64'(bus.dout), 64'h5A);

        step(NO_OP, 32'h0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_dp.md
Name: fifo_dp

Overview:
- Sequential datapath and state-register stage of the 8-entry FIFO.
- Sits directly downstream of fifo_ns:
  - registers fifo_ns's next_state;
  - updates head/tail pointers, occupancy count and storage;
  - feeds state and data_count back to fifo_ns;
  - drives the FIFO status and handshake outputs.
- fifo_ns + fifo_dp together form the complete FIFO.

Parameters:
- DATA_WIDTH, 32, width of din/dout and each storage word.
- ADDR_WIDTH, 3, pointer width; depth = 2**ADDR_WIDTH = 8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- next_state  input  3  next-state code from fifo_ns.
- din  input  DATA_WIDTH  write data, sampled at the edge where next_state==WRITE.
- state  output  3  registered current state, fed back to fifo_ns.
- data_count  output  ADDR_WIDTH+1  number of valid entries (0..8), fed back to fifo_ns.
- dout  output  DATA_WIDTH  registered read data.
- full  output  1  data_count==8.
- empty  output  1  data_count==0.
- wr_ack  output  1  state==WRITE.
- wr_err  output  1  state==WR_ERROR.
- rd_ack  output  1  state==READ.
- rd_err  output  1  state==RD_ERROR.

Behaviour:
- Decided interface: one clock (clk). Reset reset_n is asynchronous and active-low.
- Reset (reset_n=0, any time, including mid-operation):
  - state=INIT(000), head=0, tail=0, data_count=0, dout=0.
  - Hence full=0, empty=1, all ack/err=0.
  - Storage contents are don't-care.
- Each rising edge: state<=next_state. Datapath action is selected by next_state in the same edge, so the effect is visible one cycle after fifo_ns decides.
- State encodings: INIT 000, WRITE 001, WR_ERROR 010, READ 011, RD_ERROR 100, NO_OP 101.
- Action per next_state:
  - INIT: head=0, tail=0, data_count=0; dout holds.
  - WRITE: mem[tail]<=din; tail<=tail+1 (wraps 7->0); data_count+1.
  - READ: dout<=mem[head]; head<=head+1 (wraps 7->0); data_count-1.
  - WR_ERROR, RD_ERROR, NO_OP: pointers, count, storage and dout all hold.
  - Illegal codes 110/111: state<=NO_OP; everything else holds.
- Defensive guards, independent of fifo_ns correctness:
  - WRITE with data_count==8: treated as WR_ERROR; state<=WR_ERROR, no storage or pointer change.
  - READ with data_count==0: treated as RD_ERROR; state<=RD_ERROR.
- Arithmetic:
  - Pointers wrap modulo 8 by natural ADDR_WIDTH overflow.
  - data_count never leaves 0..8.
  - Invariant: tail-head (mod 8) == data_count mod 8.
- Timing of outputs:
  - full, empty and the ack/err flags are Moore outputs, decoded from registered state/data_count; no combinational path from inputs.
  - Read latency: dout valid in the cycle where rd_ack=1.
- Simultaneous read/write does not exist at this stage; fifo_ns resolves priority into one next_state.

Decomposition:
- Shared package fifo_pkg:
  - state codes INIT, WRITE, WR_ERROR, READ, RD_ERROR, NO_OP as 3-bit localparams;
  - DEPTH derived from ADDR_WIDTH.
  - fifo_ns and fifo_dp both use it.
- One sub-module, fifo_mem:
  - 8xDATA_WIDTH register file;
  - synchronous write (we, waddr, wdata);
  - combinational read (raddr -> rdata).
  - fifo_dp owns the pointers and the dout register.

Test Plan:
1. Reset mid-stream:
   - Stimulus: after 3 writes, pulse reset_n=0 asynchronously between edges.
   - Response: immediately state=000, data_count=0, empty=1, dout=0, all flags 0.
2. Fill to full:
   - Stimulus: next_state=WRITE for 8 edges with din=32'h11..32'h88.
   - Response: wr_ack=1 each following cycle; data_count steps 1..8; full=1 after 8th edge, empty=0.
   - Extra stimulus: 9th WRITE.
   - Extra response: state=WR_ERROR, wr_err=1, count stays 8.
3. Drain in order:
   - Stimulus: from full, next_state=READ for 8 edges.
   - Response: dout=11,22,...,88 with rd_ack=1; count down to 0; empty=1.
   - Extra stimulus: 9th READ.
   - Extra response: state=RD_ERROR, rd_err=1, dout holds 88.
4. Wrap-around:
   - Stimulus: write 5, read 5, write 6 (AA..FF), read 6.
   - Response: pointers wrap past 7; reads return AA..FF in order; count ends 0.
5. Hold states:
   - Stimulus: with count=3, apply NO_OP, WR_ERROR, RD_ERROR, then 3'b111.
   - Response: count, dout and pointers unchanged; last edge gives state=NO_OP.
6. INIT flush:
   - Stimulus: with count=4, apply next_state=INIT.
   - Response: count=0, empty=1.
   - Follow-up: next WRITE(din=5A) then READ returns 5A.
